rom_arbiter: RTL
================

# rom_arbiter

Two-port arbiter and sequencer for the instruction ROM. It shares the single combinational-read ROM port between the core's instruction-fetch requester (I) and data-load requester (D). It performs round-robin arbitration, window/alignment checking and a fixed three-cycle read sequence, and it returns registered data to the winning requester. It sits between the core's bus interfaces and `memory_rom`.

## Interface
Clocking: one clock; reset is asynchronous and active-high.

Parameters:
- `ROM_ORIGIN`, 32'h0, base byte address of the ROM window.
- `ROM_LENGTH`, 32'h10000, window size in bytes.

Ports:
- `iCLK`  in  1  system clock
- `iRST`  in  1  asynchronous active-high reset
- `iI_REQ`  in  1  fetch request, held until `oI_VALID`
- `iI_ADDR`  in  32  fetch byte address, stable while `iI_REQ`
- `oI_VALID`  out  1  one-cycle response strobe
- `oI_DATA`  out  32  response word
- `oI_ERR`  out  1  response is an error (qualifies `oI_VALID`)
- `iD_REQ`, `iD_ADDR`, `oD_VALID`, `oD_DATA`, `oD_ERR`: same as the I port, for loads
- `oROM_CE`  out  1  ROM chip enable
- `oROM_RD`  out  1  ROM read enable
- `oROM_ADDR`  out  32  ROM byte address
- `iROM_DATA`  in  32  ROM combinational read data
- `oBUSY`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, READ, RESP. From reset the FSM is in IDLE.
- IDLE:
  - If either REQ is high, pick a winner and latch its address and id (`sel`), then go to READ. Otherwise stay in IDLE.
  - Compute `err` = (addr < ROM_ORIGIN) | (addr >= ROM_ORIGIN+ROM_LENGTH) | (addr[1:0] != 0). Register it with the address.
- READ:
  - `oROM_ADDR` = latched address.
  - `oROM_CE` = `oROM_RD` = !err.
  - At the end of the cycle, capture `iROM_DATA` into the data register, or 32'h0 if err. Go to RESP.
- RESP:
  - Assert `o<sel>_VALID`=1, `o<sel>_DATA`=captured word, `o<sel>_ERR`=err.
  - The other port's outputs stay 0.
  - Update `last` to `sel`. Go to IDLE.
- Arbitration:
  - A single requester always wins.
  - When both request, the winner is the port not equal to `last`.
  - `last` resets to D, so I wins the first tie.
- Range check arithmetic is 33-bit unsigned. An origin+length that overflows 32 bits must not wrap.
- Error transactions keep the same latency. The ROM is never enabled for them.
- Outputs with registered sources: all VALID, DATA and ERR outputs; the ROM outputs are decoded from registered state and address.
- Reset values: every output is 0. The FSM returns to IDLE and `last`=D.

## Timing
- Edge k: IDLE samples REQ high.
- Cycle k..k+1: READ, with the ROM enabled.
- Edge k+1: data is captured.
- Cycle k+1..k+2: VALID is high.
- Edge k+2: the requester samples VALID. The FSM returns to IDLE.
- Request-to-VALID latency is 2 edges. Occupancy is 3 cycles per transaction. Throughput is 1 word per 3 cycles.
- A requester may drop REQ or change ADDR only after the edge at which VALID was sampled high. REQ still high in the following IDLE cycle is a new request.
- Simultaneous continuous requests from both ports alternate I, D, I, D…
- REQ asserted during READ or RESP waits. It is not lost, because the requester holds it.
- Reset asserted mid-transaction: the transaction is dropped immediately (asynchronously) and no VALID is produced. After reset release the requester must still be holding REQ; it is re-arbitrated from IDLE.
- Both REQ low in IDLE: no ROM activity, `oBUSY`=0.

## Structure
- Package `rom_arb_pkg`:
  - FSM state encoding: IDLE=2'd0, READ=2'd1, RESP=2'd2.
  - Requester ids: PORT_I=1'b0, PORT_D=1'b1.
- Sub-module `rom_arb_rr2`: a 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Output: grant id.
  - Purely combinational, reused by later bus arbiters.
- The top module holds the FSM, the address/err/data registers, `last`, and output decode.

## Test plan
- Reset, then I alone requests 0x4 with ROM word 1 = 0x00000013:
  - ROM enabled with address 0x4 for one cycle.
  - `oI_VALID`=1, `oI_DATA`=0x00000013, `oI_ERR`=0 two edges after sampling.
- Reset, then I (0x0) and D (0x8) request simultaneously and hold:
  - I is served first, then D 3 cycles later.
  - Held continuously, the pattern is I, D, I, D.
- D requests 0x10000 (out of window):
  - `oD_VALID`=1, `oD_ERR`=1, `oD_DATA`=0.
  - `oROM_CE` stays 0 throughout.
- I requests 0x6 (misaligned): `oI_ERR`=1, data 0, same latency as a good read.
- `iRST` pulsed during READ of a D request to 0xC:
  - All outputs are 0 immediately.
  - No `oD_VALID` appears.
  - After release with REQ still held, the read completes normally.
- ROM_ORIGIN=32'hFFFF0000, ROM_LENGTH=32'h10000:
  - Address 0xFFFFFFFC is accepted (ERR=0).
  - Address 0x0 is rejected (ERR=1).

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the instruction-ROM arbiter: FSM encoding,
// requester ids and the ROM window check.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Window bounds are compared in 33 bits so an origin+length that reaches
    // past 2^32 keeps the top of the address space inside the window.
    function automatic logic addr_err(input logic [31:0] addr,
                                      input logic [31:0] origin,
                                      input logic [31:0] length);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, origin};
        hi = lo + {1'b0, length};
        return (a < lo) | (a >= hi) | (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/rom_arb_rr2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port
// that was not served last.
module rom_arb_rr2
    import rom_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = PORT_I;
        if (req == 2'b11) begin
            grant = ~last;
        end else if (req[PORT_D]) begin
            grant = PORT_D;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the single combinational ROM port between instruction fetch (I) and
// data load (D) with a fixed IDLE/READ/RESP sequence per transaction.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter logic [31:0] ROM_ORIGIN = 32'h0,
    parameter logic [31:0] ROM_LENGTH = 32'h10000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iI_REQ,
    input  logic [31:0] iI_ADDR,
    output logic        oI_VALID,
    output logic [31:0] oI_DATA,
    output logic        oI_ERR,
    input  logic        iD_REQ,
    input  logic [31:0] iD_ADDR,
    output logic        oD_VALID,
    output logic [31:0] oD_DATA,
    output logic        oD_ERR,
    output logic        oROM_CE,
    output logic        oROM_RD,
    output logic [31:0] oROM_ADDR,
    input  logic [31:0] iROM_DATA,
    output logic        oBUSY
);

    state_t      state;
    state_t      state_next;
    logic [31:0] addr_q;
    logic        err_q;
    logic        sel_q;
    logic        last_q;
    logic        grant;
    logic [1:0]  req;
    logic [31:0] grant_addr;

    assign req        = {iD_REQ, iI_REQ};
    assign grant_addr = (grant == PORT_D) ? iD_ADDR : iI_ADDR;

    rom_arb_rr2 u_rr2 (
        .req   (req),
        .last  (last_q),
        .grant (grant)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state    <= IDLE;
            addr_q   <= 32'h0;
            err_q    <= 1'b0;
            sel_q    <= PORT_I;
            last_q   <= PORT_D;
            oI_VALID <= 1'b0;
            oI_DATA  <= 32'h0;
            oI_ERR   <= 1'b0;
            oD_VALID <= 1'b0;
            oD_DATA  <= 32'h0;
            oD_ERR   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (|req) begin
                        addr_q <= grant_addr;
                        err_q  <= addr_err(grant_addr, ROM_ORIGIN, ROM_LENGTH);
                        sel_q  <= grant;
                    end
                end
                READ: begin
                    // Response registers load at the end of READ so VALID is high during RESP
                    oI_VALID <= (sel_q == PORT_I);
                    oI_ERR   <= (sel_q == PORT_I) & err_q;
                    oI_DATA  <= ((sel_q == PORT_I) && !err_q) ? iROM_DATA : 32'h0;
                    oD_VALID <= (sel_q == PORT_D);
                    oD_ERR   <= (sel_q == PORT_D) & err_q;
                    oD_DATA  <= ((sel_q == PORT_D) && !err_q) ? iROM_DATA : 32'h0;
                end
                RESP: begin
                    oI_VALID <= 1'b0;
                    oI_ERR   <= 1'b0;
                    oI_DATA  <= 32'h0;
                    oD_VALID <= 1'b0;
                    oD_ERR   <= 1'b0;
                    oD_DATA  <= 32'h0;
                    last_q   <= sel_q;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next = state;
        oROM_CE    = 1'b0;
        oROM_RD    = 1'b0;
        oROM_ADDR  = 32'h0;
        oBUSY      = (state != IDLE);
        case (state)
            IDLE: begin
                if (|req) begin
                    state_next = READ;
                end
            end
            READ: begin
                oROM_CE    = !err_q;
                oROM_RD    = !err_q;
                oROM_ADDR  = addr_q;
                state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
